// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP transmitter: FSM state encoding,
// counter width and the idle data value.
package dvp_tx_pkg;

  localparam int unsigned CntW = 16;
  typedef logic [CntW-1:0] cnt_t;

  typedef logic [2:0] state_t;
  localparam state_t StIdle   = 3'd0;
  localparam state_t StVFront = 3'd1;
  localparam state_t StVPre   = 3'd2;
  localparam state_t StActive = 3'd3;
  localparam state_t StHBlank = 3'd4;
  localparam state_t StVPost  = 3'd5;

  localparam logic [7:0] RstData = 8'h00;

  // vsync is high for every in-frame state; only IDLE and V_FRONT are blanking
  function automatic logic vsync_of(input state_t s);
    return (s == StVPre) || (s == StActive) || (s == StHBlank) || (s == StVPost);
  endfunction

endpackage

// File: rtl/dvp_tx_if.sv
// Upstream byte stream (valid/ready) feeding the DVP transmitter.
interface dvp_tx_if;

  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);

endinterface

// File: rtl/dvp_tx_timing.sv
// Frame timing FSM for the DVP transmitter: walks blanking/active phases and
// tracks column (per-state) and line counters.
module dvp_tx_timing
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_PRE    = 32,
  parameter int unsigned V_POST   = 32,
  parameter int unsigned V_FRONT  = 1024
) (
  input  logic   cmos_pclk,
  input  logic   sys_rstn,
  input  logic   tx_en_i,
  output state_t state_o,
  output cnt_t   col_o,
  output cnt_t   line_o,
  output logic   last_col_o,
  output logic   last_line_o
);

  if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_BLANK == 0 || V_PRE == 0 || V_POST == 0 ||
      V_FRONT == 0) begin : g_bad_cfg
    $error("dvp_tx_timing: timing parameters must all be non-zero");
  end

  state_t state_q, state_d;
  cnt_t   col_q, col_d;
  cnt_t   line_q, line_d;
  cnt_t   col_last;
  logic   last_col, last_line;

  always_comb begin
    unique case (state_q)
      StVFront: col_last = cnt_t'(V_FRONT - 1);
      StVPre:   col_last = cnt_t'(V_PRE - 1);
      StActive: col_last = cnt_t'(H_ACTIVE - 1);
      StHBlank: col_last = cnt_t'(H_BLANK - 1);
      StVPost:  col_last = cnt_t'(V_POST - 1);
      default:  col_last = '0;
    endcase
  end

  assign last_col  = (col_q == col_last);
  assign last_line = (line_q == cnt_t'(V_ACTIVE - 1));

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    unique case (state_q)
      StIdle:   if (tx_en_i) state_d = StVFront;
      StVFront: if (last_col) state_d = StVPre;
      StVPre: begin
        if (last_col) begin
          state_d = StActive;
          line_d  = '0;
        end
      end
      StActive: if (last_col) state_d = last_line ? StVPost : StHBlank;
      StHBlank: begin
        if (last_col) begin
          state_d = StActive;
          line_d  = line_q + 1'b1;
        end
      end
      StVPost:  if (last_col) state_d = tx_en_i ? StVFront : StIdle;
      default:  state_d = StIdle;
    endcase
    // Column restarts on every state entry and is parked while idle
    col_d = ((state_d != state_q) || (state_q == StIdle)) ? '0 : col_q + 1'b1;
  end

  always_ff @(posedge cmos_pclk) begin
    if (!sys_rstn) begin
      state_q <= StIdle;
      col_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
    end
  end

  assign state_o     = state_q;
  assign col_o       = col_q;
  assign line_o      = line_q;
  assign last_col_o  = last_col;
  assign last_line_o = last_line;

endmodule

// File: rtl/dvp_tx.sv
// DVP transmitter top: registered vsync/href/data, upstream handshake, underrun
// flag and frame counter. Define DVP_TX_PATTERN_EN to add the pattern_en port.
module dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 144,
  parameter int unsigned V_PRE    = 32,
  parameter int unsigned V_POST   = 32,
  parameter int unsigned V_FRONT  = 1024
) (
  input  logic       cmos_pclk,
  input  logic       sys_rstn,
  input  logic       tx_en,
`ifdef DVP_TX_PATTERN_EN
  input  logic       pattern_en,
`endif
  dvp_tx_if.slave    pix,
  input  logic       underrun_clr,
  output logic       cmos_vsync,
  output logic       cmos_href,
  output logic [7:0] cmos_data,
  output logic       frame_start,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       underrun
);

  state_t state;
  cnt_t   col, line;
  logic   last_col, last_line;

  dvp_tx_timing #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .H_BLANK (H_BLANK),
    .V_PRE   (V_PRE),
    .V_POST  (V_POST),
    .V_FRONT (V_FRONT)
  ) u_timing (
    .cmos_pclk  (cmos_pclk),
    .sys_rstn   (sys_rstn),
    .tx_en_i    (tx_en),
    .state_o    (state),
    .col_o      (col),
    .line_o     (line),
    .last_col_o (last_col),
    .last_line_o(last_line)
  );

  logic       active, use_pattern;
  logic       vsync_q, vsync_d, href_q, href_d;
  logic [7:0] data_q, data_d, cnt_q, cnt_d;
  logic       fs_q, fs_d, fd_q, fd_d, underrun_q, underrun_d;

  assign active = (state == StActive);

`ifdef DVP_TX_PATTERN_EN
  logic pattern_q, pattern_d;
  logic unused_timing;

  // Latched only before the frame's active region so it cannot switch mid-frame
  assign pattern_d     = ((state == StIdle) || (state == StVFront)) ? pattern_en : pattern_q;
  assign use_pattern   = pattern_q;
  assign unused_timing = ^{col[CntW-1:8], line[CntW-1:8], last_col, last_line};

  always_ff @(posedge cmos_pclk) begin
    if (!sys_rstn) pattern_q <= 1'b0;
    else           pattern_q <= pattern_d;
  end
`else
  logic unused_timing;

  assign use_pattern   = 1'b0;
  assign unused_timing = ^{col, line, last_col, last_line};
`endif

  assign pix.pix_ready = active & ~use_pattern;

  always_comb begin
    vsync_d = vsync_of(state);
    href_d  = active;
    data_d  = RstData;
    if (active) begin
`ifdef DVP_TX_PATTERN_EN
      if (use_pattern) data_d = col[7:0] ^ line[7:0];
      else if (pix.pix_valid) data_d = pix.pix_data;
`else
      if (pix.pix_valid) data_d = pix.pix_data;
`endif
    end
    fs_d       = vsync_d & ~vsync_q;
    fd_d       = ~vsync_d & vsync_q;
    cnt_d      = fd_d ? cnt_q + 8'd1 : cnt_q;
    // Set has priority over a simultaneous clear
    underrun_d = (active & ~use_pattern & ~pix.pix_valid) | (underrun_q & ~underrun_clr);
  end

  always_ff @(posedge cmos_pclk) begin
    if (!sys_rstn) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      data_q     <= RstData;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      cnt_q      <= 8'd0;
      underrun_q <= 1'b0;
    end else begin
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      data_q     <= data_d;
      fs_q       <= fs_d;
      fd_q       <= fd_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
    end
  end

  assign cmos_vsync  = vsync_q;
  assign cmos_href   = href_q;
  assign cmos_data   = data_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_cnt   = cnt_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_dvp_tx.sv
// Directed bench for dvp_tx with a small frame (4x2, short blanking).
module tb_dvp_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_en = 1'b0;
  logic       clr = 1'b0;
`ifdef DVP_TX_PATTERN_EN
  logic       pattern_en = 1'b0;
`endif
  logic       vsync, href, fs, fd, urun;
  logic [7:0] data, fcnt;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   idx = 0;
  logic hs;

  dvp_tx_if u_if ();

  dvp_tx #(
    .H_ACTIVE(4),
    .V_ACTIVE(2),
    .H_BLANK (3),
    .V_PRE   (2),
    .V_POST  (2),
    .V_FRONT (5)
  ) dut (
    .cmos_pclk   (clk),
    .sys_rstn    (rstn),
    .tx_en       (tx_en),
`ifdef DVP_TX_PATTERN_EN
    .pattern_en  (pattern_en),
`endif
    .pix         (u_if),
    .underrun_clr(clr),
    .cmos_vsync  (vsync),
    .cmos_href   (href),
    .cmos_data   (data),
    .frame_start (fs),
    .frame_done  (fd),
    .frame_cnt   (fcnt),
    .underrun    (urun)
  );

  always #5 clk = ~clk;

  // Upstream source: presents 0x10 + number of bytes already consumed
  task automatic step();
    hs = u_if.pix_ready & u_if.pix_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) idx++;
    u_if.pix_data = 8'h10 + 8'(idx);
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @%0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @%0d: observed %02h expected %02h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_vsync"}, vsync, 1'b0);
    chk1({tag, "_href"}, href, 1'b0);
    chk8({tag, "_data"}, data, 8'h00);
    chk1({tag, "_ready"}, u_if.pix_ready, 1'b0);
    chk1({tag, "_fstart"}, fs, 1'b0);
    chk1({tag, "_fdone"}, fd, 1'b0);
    chk8({tag, "_fcnt"}, fcnt, 8'h00);
    chk1({tag, "_underrun"}, urun, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_d;
    logic [7:0] pat_l0 [4];
    logic [7:0] pat_l1 [4];
    pat_l0 = '{8'h00, 8'h01, 8'h02, 8'h03};
    pat_l1 = '{8'h01, 8'h00, 8'h03, 8'h02};

    u_if.pix_valid = 1'b1;
    u_if.pix_data  = 8'h10;
    step();
    step();
    chk_reset_vals("reset");

    // Frame 1: enable sampled at edge 1, vsync high on edges 7..21
    rstn  = 1'b1;
    cyc   = 0;
    idx   = 0;
    u_if.pix_data = 8'h10;
    tx_en = 1'b1;
    for (int n = 1; n <= 22; n++) begin
      step();
      if (n >= 9 && n <= 12)       exp_d = 8'h10 + 8'(n - 9);
      else if (n >= 16 && n <= 19) exp_d = 8'h14 + 8'(n - 16);
      else                         exp_d = 8'h00;
      chk1("f1_vsync", vsync, (n >= 7 && n <= 21));
      chk1("f1_href", href, (n >= 9 && n <= 12) || (n >= 16 && n <= 19));
      chk8("f1_data", data, exp_d);
      chk1("f1_ready", u_if.pix_ready, (n >= 8 && n <= 11) || (n >= 15 && n <= 18));
      chk1("f1_fstart", fs, (n == 7));
      chk1("f1_fdone", fd, (n == 22));
    end
    chk8("f1_fcnt", fcnt, 8'd1);
    chk1("f1_underrun", urun, 1'b0);

    // Frame 2: period 20, underrun on third byte of line 0
    goto(27);
    chk1("f2_vsync_rise", vsync, 1'b1);
    chk1("f2_fstart", fs, 1'b1);
    goto(30);
    u_if.pix_valid = 1'b0;
    step();
    chk8("ur_data", data, 8'h00);
    chk1("ur_href", href, 1'b1);
    chk1("ur_set", urun, 1'b1);
    u_if.pix_valid = 1'b1;
    step();
    chk8("ur_next_byte", data, 8'h1a);
    chk1("ur_sticky", urun, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk1("ur_clear", urun, 1'b0);
    chk1("ur_hblank_href", href, 1'b0);
    chk8("ur_hblank_data", data, 8'h00);
    goto(35);
    u_if.pix_valid = 1'b0;
    clr = 1'b1;
    step();
    chk1("ur_set_wins", urun, 1'b1);
    chk8("ur_l1_data", data, 8'h00);
    u_if.pix_valid = 1'b1;
    clr = 1'b0;
    step();
    chk8("ur_l1_next", data, 8'h1b);
    chk1("ur_l1_href", href, 1'b1);

    // Drop enable in line 1: frame completes, then idle
    tx_en = 1'b0;
    goto(41);
    chk1("stop_vsync_hold", vsync, 1'b1);
    chk1("stop_no_fdone", fd, 1'b0);
    step();
    chk1("stop_vsync_fall", vsync, 1'b0);
    chk1("stop_fdone", fd, 1'b1);
    chk8("stop_fcnt", fcnt, 8'd2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk1("stop_ur_clear", urun, 1'b0);
    goto(50);
    chk1("idle_vsync", vsync, 1'b0);
    chk1("idle_href", href, 1'b0);
    chk1("idle_ready", u_if.pix_ready, 1'b0);
    chk1("idle_fdone", fd, 1'b0);
    chk8("idle_fcnt", fcnt, 8'd2);

    // Restart, then reset during ACTIVE (first active cycle is 58)
    tx_en = 1'b1;
    goto(58);
    chk1("rs_ready", u_if.pix_ready, 1'b1);
    u_if.pix_valid = 1'b0;
    step();
    chk1("rs_href_pre", href, 1'b1);
    chk1("rs_ur_pre", urun, 1'b1);
    u_if.pix_valid = 1'b1;
    rstn = 1'b0;
    step();
    chk_reset_vals("midrst");
    rstn = 1'b1;
    goto(66);
    chk1("rs_vsync_low", vsync, 1'b0);
    step();
    chk1("rs_vsync_rise", vsync, 1'b1);
    chk1("rs_fstart", fs, 1'b1);

    // 256 frames after restart: frame_done at 82 + 20k
    goto(82);
    chk1("wrap_fd_first", fd, 1'b1);
    chk8("wrap_cnt_first", fcnt, 8'd1);
    goto(5181);
    chk8("wrap_cnt_255", fcnt, 8'd255);
    step();
    chk1("wrap_fd_last", fd, 1'b1);
    chk8("wrap_cnt_0", fcnt, 8'd0);

`ifdef DVP_TX_PATTERN_EN
    // Pattern mode from a fresh reset; upstream deliberately not valid
    rstn = 1'b0;
    pattern_en = 1'b1;
    u_if.pix_valid = 1'b0;
    step();
    rstn = 1'b1;
    cyc  = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk1("pat_ready", u_if.pix_ready, 1'b0);
      if (n >= 9 && n <= 12) chk8("pat_l0", data, pat_l0[n - 9]);
      if (n >= 16 && n <= 19) chk8("pat_l1", data, pat_l1[n - 16]);
    end
    chk1("pat_no_underrun", urun, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
